c64_mouse_1351: RTL and testbench
=================================

# c64_mouse_1351

Commodore 1351 proportional-mouse emulator. It sits directly downstream of the HID block's mouse outputs. It takes the per-report button state and signed X/Y deltas, accumulates them, and meters them out at a fixed tick rate into 6-bit wrapping positions. Those positions are presented as SID POTX/POTY register values and as active-low joystick button lines on the selected control port.

## Interface
Parameters:
- `UPDATE_DIV`, default 32000: clocks per position-update tick (1 ms at 32 MHz); minimum 2.
- `MAX_STEP`, default 31: largest per-axis position change applied per tick; range 1..31.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  mouse emulation active. When low, the block is forced idle (see Operation).
- `mouse_btns`  in  2  bit0 = left button, bit1 = right button; active-high.
- `mouse_x`  in  8  signed two's-complement X delta; positive means right.
- `mouse_y`  in  8  signed two's-complement Y delta; positive means down (HID convention).
- `mouse_strobe`  in  1  one-cycle pulse; `mouse_btns`, `mouse_x` and `mouse_y` are valid in this cycle.
- `pot_x`  out  8  SID POTX value: `{1'b0, pos_x[5:0], noise}`.
- `pot_y`  out  8  SID POTY value: `{1'b0, pos_y[5:0], noise}`.
- `mouse_joy`  out  5  active-low joystick lines `{fire, right, left, down, up}`.
- `busy`  out  1  high while either pending accumulator is non-zero.

## Operation
- **State held:**
  - `pend_x`, `pend_y`: 10-bit signed pending accumulators, saturating at −512/+511.
  - `pos_x`, `pos_y`: 6-bit positions that wrap modulo 64.
  - `tick_cnt`: counts 0..`UPDATE_DIV`−1.
  - `lfsr`: 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 0xA5.
- **Strobe:** on `mouse_strobe`, the block computes
  - `dx = sext(mouse_x)`
  - `dy = −sext(mouse_y)` (Y is inverted, so moving up increases POTY)
  - `pend_x <= sat(pend_x + dx)`, `pend_y <= sat(pend_y + dy)`
  - `mouse_btns` is latched into the button register.
- **Tick:** `tick_cnt` wraps from `UPDATE_DIV`−1 to 0. In the wrap cycle:
  - `step = clamp(pend, −MAX_STEP, +MAX_STEP)` per axis.
  - `pos <= pos + step[5:0]` (mod 64).
  - `pend <= pend − step`.
  - `lfsr` advances one step.
- **Strobe and tick in the same cycle:** `step` is computed from the old `pend`, and `pend_next = sat(pend − step + delta)`. No delta is lost.
- **Outputs:**
  - `noise = lfsr[0]`.
  - `mouse_joy[4] = ~btn_left` (fire); `mouse_joy[0] = ~btn_right` (up); `mouse_joy[3:1] = 3'b111`.
- **enable low:**
  - `pend` cleared; `tick_cnt` held at 0; strobes ignored; buttons cleared.
  - `pot_x = pot_y = 8'hFF`; `mouse_joy = 5'b11111`.
  - `pos` retains its value.
- **enable 0→1:** the first tick occurs `UPDATE_DIV` cycles later. `pot` outputs show the retained `pos` from the first enabled cycle.

## Timing
- All outputs are registered. Every input affects outputs exactly one clock after its cause.
- **Reset values:**
  - `pend` = 0, `pos` = 0, `tick_cnt` = 0, `lfsr` = 0xA5, buttons = 0.
  - `pot_x = pot_y = 8'h01`, `mouse_joy = 5'b11111`, `busy = 0`.
- **Reset mid-operation:** `reset` overrides `enable`, `mouse_strobe` and tick in the same cycle. All state returns to reset values; no partial step is applied.
- **Button latency:** strobe cycle N gives `mouse_joy` updated at N+1.
- **Position latency:** `pot` outputs update at tick cycle + 1. A delta of magnitude m is fully applied after ceil(m/`MAX_STEP`) ticks.
- **busy:** registered as `(pend_x != 0) | (pend_y != 0)`, evaluated on the next-state values.
- **Saturation:**
  - Repeated strobes of +127 clamp `pend` at +511.
  - Repeated strobes of −128 clamp `pend` at −512.
  - The excess movement is discarded.
- **Wrap-around:** `pos` = 63 plus step +1 gives 0. `pos` = 0 plus step −1 gives 63.

## Test plan
- **Reset:**
  - Stimulus: reset, then run 3 ticks with `enable`=1 and no strobes.
  - Required: `pot_x = pot_y = 0x01`/LFSR bit pattern in bit 0, bits 6:1 = 0; `mouse_joy` = 0x1F; `busy` = 0.
- **Single delta:**
  - Stimulus: strobe with `mouse_x` = 0x0A, `mouse_y` = 0xFB (−5).
  - Required: after the next tick, `pot_x[6:1]` = 10 and `pot_y[6:1]` = 5; `busy` falls in the tick cycle + 1.
- **Metering:**
  - Stimulus: strobe with `mouse_x` = 0x64 (+100).
  - Required: over successive ticks `pos_x` = 31, 62, 29 (wrapped), 36; `pend_x` goes 69, 38, 7, 0.
- **Saturation:**
  - Stimulus: 6 strobes of `mouse_x` = 0x7F with no tick in between.
  - Required: `pend_x` = 511; after 17 ticks `pos_x` = 511 mod 64 = 63 and `busy` = 0.
- **Collision:**
  - Stimulus: strobe with `mouse_x` = 0x05 in exactly the tick cycle, with `pend_x` = 40.
  - Required: that tick gives step 31 and `pend_x` = 14; the next tick gives `pos` +14 and `pend_x` = 0.
- **Buttons and enable:**
  - Stimulus: strobe with `btns` = 2'b11, then drop `enable`.
  - Required:
    - With `btns` = 2'b11: `mouse_joy` = 5'b01110 one cycle after the strobe.
    - After `enable` drops: `mouse_joy` = 0x1F and `pot` = 0xFF one cycle later; strobes are ignored while low.
    - After `enable` rises again: the retained `pos` reappears.

Source files
------------

// File: rtl/c64_mouse_1351.sv
// Commodore 1351 proportional-mouse emulator: HID deltas -> SID POTX/POTY + joystick buttons.
// Latency: every output is registered, one clock after its cause; positions move only on ticks.
// Backpressure: none; strobes are always accepted, excess movement saturates in the accumulators.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   enable                emulation active; low forces the block idle (pos is retained)
//   mouse_btns[1:0]       {right, left}, active-high, sampled on mouse_strobe
//   mouse_x/mouse_y[7:0]  signed deltas (Y positive = down), sampled on mouse_strobe
//   mouse_strobe          one-cycle pulse qualifying btns/x/y
//   pot_x/pot_y[7:0]      {1'b0, pos[5:0], noise}; 8'hFF while disabled
//   mouse_joy[4:0]        active-low {fire, right, left, down, up}
//   busy                  pending movement not yet metered out
module c64_mouse_1351 #(
  parameter int UPDATE_DIV = 32000,
  parameter int MAX_STEP   = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mouse_btns,
  input  logic [7:0] mouse_x,
  input  logic [7:0] mouse_y,
  input  logic       mouse_strobe,
  output logic [7:0] pot_x,
  output logic [7:0] pot_y,
  output logic [4:0] mouse_joy,
  output logic       busy
);

  localparam int CW = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(UPDATE_DIV - 1);
  localparam logic signed [9:0] STEP_HI = 10'(MAX_STEP);
  localparam logic signed [9:0] STEP_LO = -10'(MAX_STEP);

  logic [CW-1:0]      tick_cnt, tick_cnt_nx;
  logic signed [9:0]  pend_x, pend_y, pend_x_nx, pend_y_nx;
  logic [5:0]         pos_x, pos_y, pos_x_nx, pos_y_nx;
  logic [7:0]         lfsr, lfsr_nx;
  logic               btn_l, btn_r, btn_l_nx, btn_r_nx;
  logic               tick, take;
  logic signed [5:0]  step_x, step_y;
  logic signed [11:0] dx, dy;

  // Per-tick movement limit; step fits in 6 bits signed since MAX_STEP <= 31.
  function automatic logic signed [5:0] clamp_step(input logic signed [9:0] p);
    logic signed [9:0] c;
    c = p;
    if (p > STEP_HI) c = STEP_HI;
    if (p < STEP_LO) c = STEP_LO;
    return c[5:0];
  endfunction

  // Clamp a widened accumulator result back into the 10-bit signed range.
  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    logic signed [9:0] r;
    r = v[9:0];
    if (v > 12'sd511)  r = 10'sd511;
    if (v < -12'sd512) r = -10'sd512;
    return r;
  endfunction

  always_comb begin
    tick   = enable && (tick_cnt == TICK_LAST);
    take   = enable && mouse_strobe;
    step_x = tick ? clamp_step(pend_x) : 6'sd0;
    step_y = tick ? clamp_step(pend_y) : 6'sd0;
    // Y is inverted so that moving the mouse up increases POTY.
    dx     = take ? {{4{mouse_x[7]}}, mouse_x} : 12'sd0;
    dy     = take ? -{{4{mouse_y[7]}}, mouse_y} : 12'sd0;

    tick_cnt_nx = '0;
    pend_x_nx   = '0;
    pend_y_nx   = '0;
    pos_x_nx    = pos_x;
    pos_y_nx    = pos_y;
    lfsr_nx     = lfsr;
    btn_l_nx    = 1'b0;
    btn_r_nx    = 1'b0;

    if (enable) begin
      tick_cnt_nx = tick ? '0 : tick_cnt + CW'(1);
      // Step comes from the old pend, so a strobe coinciding with a tick loses nothing.
      pend_x_nx   = sat10({{2{pend_x[9]}}, pend_x} - {{6{step_x[5]}}, step_x} + dx);
      pend_y_nx   = sat10({{2{pend_y[9]}}, pend_y} - {{6{step_y[5]}}, step_y} + dy);
      pos_x_nx    = pos_x + $unsigned(step_x);
      pos_y_nx    = pos_y + $unsigned(step_y);
      if (tick) lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      btn_l_nx    = take ? mouse_btns[0] : btn_l;
      btn_r_nx    = take ? mouse_btns[1] : btn_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      lfsr      <= 8'hA5;
      btn_l     <= 1'b0;
      btn_r     <= 1'b0;
      pot_x     <= 8'h01;
      pot_y     <= 8'h01;
      mouse_joy <= 5'b11111;
      busy      <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt_nx;
      pend_x    <= pend_x_nx;
      pend_y    <= pend_y_nx;
      pos_x     <= pos_x_nx;
      pos_y     <= pos_y_nx;
      lfsr      <= lfsr_nx;
      btn_l     <= btn_l_nx;
      btn_r     <= btn_r_nx;
      pot_x     <= enable ? {1'b0, pos_x_nx, lfsr_nx[0]} : 8'hFF;
      pot_y     <= enable ? {1'b0, pos_y_nx, lfsr_nx[0]} : 8'hFF;
      mouse_joy <= enable ? {~btn_l_nx, 3'b111, ~btn_r_nx} : 5'b11111;
      busy      <= (pend_x_nx != 10'sd0) || (pend_y_nx != 10'sd0);
    end
  end

endmodule

// File: tb/tb_c64_mouse_1351.sv
// Bench for c64_mouse_1351: a behavioural model pushes the expected outputs for
// every driven cycle into a queue, which is popped and compared after the edge;
// directed checks add the hand-derived values for each scenario.
module tb_c64_mouse_1351;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mouse_btns = 2'b00;
  logic [7:0] mouse_x = 8'h00;
  logic [7:0] mouse_y = 8'h00;
  logic       mouse_strobe = 1'b0;
  logic [7:0] pot_x, pot_y;
  logic [4:0] mouse_joy;
  logic       busy;

  c64_mouse_1351 #(.UPDATE_DIV(DIV), .MAX_STEP(31)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mouse_btns(mouse_btns),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_strobe(mouse_strobe),
    .pot_x(pot_x), .pot_y(pot_y), .mouse_joy(mouse_joy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    logic [7:0] py;
    logic [4:0] joy;
    logic       bsy;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int       m_px, m_py, m_pdx, m_pdy, m_cnt;
  logic [7:0] m_lfsr;
  bit       m_bl, m_br, m_tick;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int clampstep(input int v);
    if (v > 31) return 31;
    if (v < -31) return -31;
    return v;
  endfunction

  function automatic int wrap64(input int v);
    return ((v % 64) + 64) % 64;
  endfunction

  // One clock: drive inputs, advance the model, push expectation, compare after the edge.
  task automatic cyc(input bit r, input bit en, input bit stb, input logic [1:0] b,
                     input logic [7:0] x, input logic [7:0] y);
    exp_t e, got;
    int   sx, sy, dxv, dyv;
    @(negedge clk);
    reset = r; enable = en; mouse_strobe = stb; mouse_btns = b; mouse_x = x; mouse_y = y;
    m_tick = 1'b0;
    if (r) begin
      m_px = 0; m_py = 0; m_pdx = 0; m_pdy = 0; m_cnt = 0;
      m_lfsr = 8'hA5; m_bl = 1'b0; m_br = 1'b0;
      e.px = 8'h01; e.py = 8'h01; e.joy = 5'h1F; e.bsy = 1'b0;
    end else if (!en) begin
      m_pdx = 0; m_pdy = 0; m_cnt = 0; m_bl = 1'b0; m_br = 1'b0;
      e.px = 8'hFF; e.py = 8'hFF; e.joy = 5'h1F; e.bsy = 1'b0;
    end else begin
      sx = 0; sy = 0;
      if (m_cnt == DIV - 1) begin
        m_tick = 1'b1;
        m_cnt  = 0;
        sx = clampstep(m_pdx);
        sy = clampstep(m_pdy);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end else begin
        m_cnt++;
      end
      m_px = wrap64(m_px + sx);
      m_py = wrap64(m_py + sy);
      dxv = stb ? int'($signed(x)) : 0;
      dyv = stb ? -int'($signed(y)) : 0;
      m_pdx = sat(m_pdx - sx + dxv);
      m_pdy = sat(m_pdy - sy + dyv);
      if (stb) begin
        m_bl = b[0];
        m_br = b[1];
      end
      e.px  = {1'b0, 6'(m_px), m_lfsr[0]};
      e.py  = {1'b0, 6'(m_py), m_lfsr[0]};
      e.joy = {~m_bl, 3'b111, ~m_br};
      e.bsy = (m_pdx != 0) || (m_pdy != 0);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sb_pot_x", pot_x, got.px);
    chk("sb_pot_y", pot_y, got.py);
    chk("sb_joy", mouse_joy, got.joy);
    chk("sb_busy", busy, got.bsy);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic strobe(input logic [1:0] b, input logic [7:0] x, input logic [7:0] y);
    cyc(1'b0, 1'b1, 1'b1, b, x, y);
  endtask

  // Reset asserted together with enable and a strobe: reset must win.
  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b1, 2'b11, 8'h7F, 8'h7F);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < n * DIV + 4) begin
      idle();
      if (m_tick) got++;
      guard++;
    end
    chk("tick_budget", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // reset state and idle ticking
    do_reset();
    chk("rst_pot_x", pot_x, 8'h01);
    chk("rst_pot_y", pot_y, 8'h01);
    chk("rst_joy", mouse_joy, 5'h1F);
    chk("rst_busy", busy, 1'b0);
    run_ticks(3);
    chk("idle_pos_x", pot_x[7:1], 7'd0);
    chk("idle_pos_y", pot_y[7:1], 7'd0);
    chk("idle_busy", busy, 1'b0);

    // single delta
    do_reset();
    strobe(2'b00, 8'h0A, 8'hFB);
    chk("single_busy_hi", busy, 1'b1);
    run_ticks(1);
    chk("single_pos_x", pot_x[6:1], 6'd10);
    chk("single_pos_y", pot_y[6:1], 6'd5);
    chk("single_busy_lo", busy, 1'b0);

    // metering +100 at 31 per tick
    do_reset();
    strobe(2'b00, 8'h64, 8'h00);
    run_ticks(1); chk("meter_pos1", pot_x[6:1], 6'd31); chk("meter_busy1", busy, 1'b1);
    run_ticks(1); chk("meter_pos2", pot_x[6:1], 6'd62); chk("meter_busy2", busy, 1'b1);
    run_ticks(1); chk("meter_pos3", pot_x[6:1], 6'd29); chk("meter_busy3", busy, 1'b1);
    run_ticks(1); chk("meter_pos4", pot_x[6:1], 6'd36); chk("meter_busy4", busy, 1'b0);

    // saturation: x to +511, y (inverted) to -512
    do_reset();
    for (int i = 0; i < 6; i++) strobe(2'b00, 8'h7F, 8'h7F);
    run_ticks(16);
    chk("sat_pos_x16", pot_x[6:1], 6'd48);
    chk("sat_pos_y16", pot_y[6:1], 6'd16);
    chk("sat_busy16", busy, 1'b1);
    run_ticks(1);
    chk("sat_pos_x17", pot_x[6:1], 6'd63);
    chk("sat_pos_y17", pot_y[6:1], 6'd0);
    chk("sat_busy17", busy, 1'b0);

    // strobe landing exactly in the tick cycle
    do_reset();
    strobe(2'b00, 8'h28, 8'h00);
    guard = 0;
    while (m_cnt != DIV - 1 && guard < 2 * DIV) begin
      idle();
      guard++;
    end
    chk("coll_reach", m_cnt, DIV - 1);
    strobe(2'b00, 8'h05, 8'h00);
    chk("coll_pos1", pot_x[6:1], 6'd31);
    chk("coll_busy1", busy, 1'b1);
    run_ticks(1);
    chk("coll_pos2", pot_x[6:1], 6'd45);
    chk("coll_busy2", busy, 1'b0);

    // buttons and enable
    do_reset();
    strobe(2'b11, 8'h03, 8'h02);
    chk("btn_joy", mouse_joy, 5'b01110);
    run_ticks(1);
    chk("btn_pos_x", pot_x[6:1], 6'd3);
    chk("btn_pos_y", pot_y[6:1], 6'd62);
    chk("btn_joy_hold", mouse_joy, 5'b01110);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    chk("dis_pot_x", pot_x, 8'hFF);
    chk("dis_pot_y", pot_y, 8'hFF);
    chk("dis_joy", mouse_joy, 5'h1F);
    cyc(1'b0, 1'b0, 1'b1, 2'b11, 8'h14, 8'h00);
    chk("dis_stb_joy", mouse_joy, 5'h1F);
    chk("dis_stb_busy", busy, 1'b0);
    idle();
    chk("reen_pos_x", pot_x[6:1], 6'd3);
    chk("reen_pos_y", pot_y[6:1], 6'd62);
    chk("reen_joy", mouse_joy, 5'h1F);
    run_ticks(1);
    chk("reen_tick_pos_x", pot_x[6:1], 6'd3);
    chk("reen_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
